// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: producer side of the control decoder interface.
// Program-loadable instruction memory plus PC; fetches one word every two
// cycles and presents decoded register/opcode fields under valid/ready.
// Optional feature macro: IFU_HALT_EN (ECALL handshake stops fetch until reset).
module instr_fetch_issue #(
    parameter  int MEM_DEPTH = 64,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [6:0]        opcode,
    output logic [4:0]        rd,
    output logic [2:0]        funct3,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [6:0]        funct7,
    output logic [15:0]       issued_count,
    output logic              halted
);

    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE
`ifdef IFU_HALT_EN
        , HALT
`endif
    } state_t;

    state_t            state, state_next;
    logic [31:0]       pc;
    logic [31:0]       mem [MEM_DEPTH];
    logic [ADDR_W-1:0] pc_idx;
    logic [ADDR_W-1:0] idx_inc;
    logic [31:0]       pc_inc;
    logic              fire;
    logic              in_halt;
    logic              halt_now;
    logic              take_redirect;

    // Only the index bits address memory; upper PC bits ride along untouched,
    // so the increment wraps within the memory window.
    assign pc_idx  = pc[ADDR_W+1:2];
    assign idx_inc = pc_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign pc_inc  = {pc[31:ADDR_W+2], idx_inc, 2'b00};

    // out_valid is only ever set in ISSUE, so it alone qualifies the handshake.
    assign fire = out_valid & out_ready;

`ifdef IFU_HALT_EN
    assign in_halt  = (state == HALT);
    assign halt_now = fire && (out_instr == ECALL);
`else
    assign in_halt  = 1'b0;
    assign halt_now = 1'b0;
`endif

    // A retiring ECALL beats a same-cycle redirect; HALT ignores redirects.
    assign take_redirect = redirect_valid & ~in_halt & ~halt_now;
    assign halted        = in_halt;

    assign opcode = out_instr[6:0];
    assign rd     = out_instr[11:7];
    assign funct3 = out_instr[14:12];
    assign rs1    = out_instr[19:15];
    assign rs2    = out_instr[24:20];
    assign funct7 = out_instr[31:25];

    // Program port: write in any state, memory contents survive reset.
    always_ff @(posedge clock) begin
        if (prog_we)
            mem[prog_addr] <= prog_data;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state: enable gates IDLE exit and ISSUE->FETCH; redirect forces FETCH.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = FETCH;
            FETCH:   state_next = ISSUE;
            ISSUE:   if (fire) state_next = enable ? FETCH : IDLE;
`ifdef IFU_HALT_EN
            HALT:    state_next = HALT;
`endif
            default: state_next = IDLE;
        endcase
        if (take_redirect)
            state_next = FETCH;
`ifdef IFU_HALT_EN
        if (halt_now)
            state_next = HALT;
`endif
    end

    // PC, issue register and counter. The FETCH read lands straight in
    // out_instr, so a same-cycle program write to that index yields old data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc           <= '0;
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_pc       <= '0;
            issued_count <= '0;
        end else begin
            if (fire)
                issued_count <= issued_count + 16'd1;
            if (take_redirect) begin
                pc        <= {redirect_pc[31:2], 2'b00};
                out_valid <= 1'b0;
            end else if (state == FETCH) begin
                out_instr <= mem[pc_idx];
                out_pc    <= pc;
                out_valid <= 1'b1;
            end else if (fire) begin
                pc        <= pc_inc;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Scoreboard bench for instr_fetch_issue: stimulus pushes expected
// {instr, pc} pairs, a negedge monitor pops and checks on every handshake.
module tb_instr_fetch_issue;

    localparam int MEM_DEPTH = 64;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    localparam logic [31:0] M0   = 32'h0020_81B3; // add x3,x1,x2
    localparam logic [31:0] M1   = 32'h4020_8233; // sub x4,x1,x2
    localparam logic [31:0] M2   = 32'h0000_0073; // ecall
    localparam logic [31:0] M3   = 32'h00C5_8533; // add x10,x11,x12
    localparam logic [31:0] M63  = 32'h0000_0013; // nop
    localparam logic [31:0] NEW0 = 32'h00A0_0093; // addi x1,x0,10

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic              clock;
    logic              reset;
    logic              enable;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_ready;
    logic              out_valid;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [6:0]        funct7;
    logic [15:0]       issued_count;
    logic              halted;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    instr_fetch_issue #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .opcode(opcode), .rd(rd), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .issued_count(issued_count), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = idx[ADDR_W-1:0];
        prog_data = data;
        step();
        prog_we   = 1'b0;
    endtask

    // Monitor: every handshake must match the oldest expected entry.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", out_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", out_instr, e.instr);
                chk("sb_pc", out_pc, e.pc);
                chk("sb_fields", {funct7, rs2, rs1, funct3, rd, opcode}, e.instr);
            end
        end
    end

    initial begin
        reset = 1'b0; enable = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        // Program memory while held in reset.
        load(0, M0); load(1, M1); load(2, M2); load(3, M3); load(63, M63);
        @(negedge clock);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_count", {16'd0, issued_count}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_opcode", {25'd0, opcode}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Back-to-back add/sub with ready held high.
        sb.push_back('{M0, 32'h0});
        sb.push_back('{M1, 32'h4});
        enable = 1'b1; out_ready = 1'b1;
        step();
        chk("lat_valid_c1", {31'd0, out_valid}, 32'd0);
        step();
        chk("lat_valid_c2", {31'd0, out_valid}, 32'd1);
        chk("add_opcode", {25'd0, opcode}, 32'h33);
        chk("add_rd", {27'd0, rd}, 32'd3);
        chk("add_rs1", {27'd0, rs1}, 32'd1);
        chk("add_rs2", {27'd0, rs2}, 32'd2);
        chk("add_f3f7", {22'd0, funct3, funct7}, 32'd0);
        chk("add_pc", out_pc, 32'h0);
        step();
        step();
        chk("sub_pc", out_pc, 32'h4);
        chk("sub_funct7", {25'd0, funct7}, 32'h20);
        enable = 1'b0;
        step();
        chk("pair_count", {16'd0, issued_count}, 32'd2);
        chk("pair_idle", {31'd0, out_valid}, 32'd0);

        // Stall: redirect with enable low still fetches; hold ready low 5 cycles.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_000C;
        sb.push_back('{M3, 32'hC});
        step();
        redirect_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_instr", out_instr, M3);
            chk("stall_pc", out_pc, 32'hC);
            chk("stall_count", {16'd0, issued_count}, 32'd2);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("stall_release_count", {16'd0, issued_count}, 32'd3);
        chk("stall_release_valid", {31'd0, out_valid}, 32'd0);
        step(); step();
        chk("stall_once", {16'd0, issued_count}, 32'd3);

        // Redirect to 0x103 in the same cycle as a handshake.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0004; enable = 1'b1;
        sb.push_back('{M1, 32'h4});
        step();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        sb.push_back('{M0, 32'h100});
        step();
        redirect_valid = 1'b0; enable = 1'b0;
        chk("redir_count", {16'd0, issued_count}, 32'd4);
        step();
        chk("redir_pc", out_pc, 32'h100);
        chk("redir_instr", out_instr, M0);
        step();
        chk("redir_done_count", {16'd0, issued_count}, 32'd5);

        // Wrap 0xFC -> 0x00; write mem[0] during the FETCH that reads it.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_00FC; enable = 1'b1;
        sb.push_back('{M63, 32'hFC});
        sb.push_back('{M0, 32'h0});
        step();
        redirect_valid = 1'b0;
        step();
        step();
        prog_we = 1'b1; prog_addr = '0; prog_data = NEW0;
        step();
        prog_we = 1'b0; enable = 1'b0;
        chk("wrap_pc", out_pc, 32'h0);
        chk("rw_old_data", out_instr, M0);
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        sb.push_back('{NEW0, 32'h0});
        step();
        redirect_valid = 1'b0;
        step();
        chk("new_data", out_instr, NEW0);
        step();
        chk("wrap_count", {16'd0, issued_count}, 32'd8);

        // Asynchronous reset while stalled in ISSUE.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h4;
        step();
        redirect_valid = 1'b0;
        step();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_count", {16'd0, issued_count}, 32'd0);
        chk("arst_pc", out_pc, 32'h0);
        step();
        reset = 1'b1;
        enable = 1'b1; out_ready = 1'b1;
        sb.push_back('{NEW0, 32'h0});
        step();
        step();
        chk("post_rst_pc", out_pc, 32'h0);
        enable = 1'b0;
        step();
        chk("post_rst_count", {16'd0, issued_count}, 32'd1);

        // ECALL behaviour.
        redirect_valid = 1'b1; redirect_pc = 32'h8; enable = 1'b1;
        sb.push_back('{M2, 32'h8});
`ifdef IFU_HALT_EN
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        step(); step();
        chk("halt_redir_valid", {31'd0, out_valid}, 32'd0);
        chk("halt_redir_flag", {31'd0, halted}, 32'd1);
        chk("halt_count", {16'd0, issued_count}, 32'd2);
`else
        sb.push_back('{M3, 32'hC});
        step();
        redirect_valid = 1'b0;
        step();
        step();
        step();
        chk("ecall_next_pc", out_pc, 32'hC);
        chk("ecall_halted", {31'd0, halted}, 32'd0);
        enable = 1'b0;
        step();
        chk("ecall_count", {16'd0, issued_count}, 32'd3);
`endif
        step();
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
